// File: rtl/prog_seq_detector.sv
`default_nettype none
// ============================================================================
// Module      : prog_seq_detector
// Description : Serial pattern detector with a loadable pattern, overlap mode
//               and a saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_seq_detector #(
    parameter int                 SEQ_LEN     = 4,
    parameter logic [SEQ_LEN-1:0] RST_PATTERN = 4'b1010,
    parameter int                 CNT_W       = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         d_in,
    input  logic                         d_valid,
    input  logic                         overlap_en,
    input  logic                         load_en,
    input  logic [SEQ_LEN-1:0]           load_pattern,
    input  logic                         cnt_clr,
    output logic                         q_out,
    output logic [CNT_W-1:0]             match_count,
    output logic [$clog2(SEQ_LEN+1)-1:0] fill
);

    localparam int               FILL_W    = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [SEQ_LEN-1:0] pattern_q, pattern_d;
    logic [SEQ_LEN-1:0] history_q, history_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               q_out_q, q_out_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [SEQ_LEN-1:0] history_shift;
    logic [FILL_W-1:0]  fill_inc;
    logic               match;

    always_comb begin
        pattern_d     = pattern_q;
        history_d     = history_q;
        fill_d        = fill_q;
        q_out_d       = 1'b0;
        match         = 1'b0;
        history_shift = {history_q[SEQ_LEN-2:0], d_in};
        fill_inc      = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

        if (load_en) begin
            pattern_d = load_pattern;
            history_d = '0;
            fill_d    = '0;
        end else if (d_valid) begin
            history_d = history_shift;
            fill_d    = fill_inc;
            if ((fill_inc == FILL_FULL) && (history_shift == pattern_q)) begin
                match   = 1'b1;
                q_out_d = 1'b1;
                // Non-overlapping mode restarts the window from scratch
                if (!overlap_en) begin
                    fill_d = '0;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (cnt_clr) begin
            count_d = '0;
        end else if (match && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q <= RST_PATTERN;
            history_q <= '0;
            fill_q    <= '0;
            q_out_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            pattern_q <= pattern_d;
            history_q <= history_d;
            fill_q    <= fill_d;
            q_out_q   <= q_out_d;
            count_q   <= count_d;
        end
    end

    assign q_out       = q_out_q;
    assign match_count = count_q;
    assign fill        = fill_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_seq_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_seq_detector
// Description : Directed self-checking bench for prog_seq_detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_seq_detector;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       d_in, d_valid, overlap_en, load_en, cnt_clr;
    logic [3:0] load_pattern;
    logic       q_out;
    logic [7:0] match_count;
    logic [2:0] fill;

    logic       s_d_in, s_d_valid, s_cnt_clr;
    logic       s_load_en;
    logic [3:0] s_load_pattern;
    logic       s_q_out;
    logic [1:0] s_match_count;
    logic [2:0] s_fill;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prog_seq_detector dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .d_in         (d_in),
        .d_valid      (d_valid),
        .overlap_en   (overlap_en),
        .load_en      (load_en),
        .load_pattern (load_pattern),
        .cnt_clr      (cnt_clr),
        .q_out        (q_out),
        .match_count  (match_count),
        .fill         (fill)
    );

    prog_seq_detector #(.CNT_W(2)) dut_sat (
        .clk          (clk),
        .reset_n      (reset_n),
        .d_in         (s_d_in),
        .d_valid      (s_d_valid),
        .overlap_en   (1'b1),
        .load_en      (s_load_en),
        .load_pattern (s_load_pattern),
        .cnt_clr      (s_cnt_clr),
        .q_out        (s_q_out),
        .match_count  (s_match_count),
        .fill         (s_fill)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one input cycle, then settle just past the rising edge
    task automatic bit_in(input logic b, input logic v);
        d_in    = b;
        d_valid = v;
        @(posedge clk);
        #1;
        d_valid = 1'b0;
    endtask

    task automatic load(input logic [3:0] pat, input logic clr);
        load_en      = 1'b1;
        load_pattern = pat;
        cnt_clr      = clr;
        d_valid      = 1'b1;
        d_in         = 1'b1;
        @(posedge clk);
        #1;
        load_en = 1'b0;
        cnt_clr = 1'b0;
        d_valid = 1'b0;
    endtask

    task automatic sbit(input logic b, input logic clr);
        s_d_in    = b;
        s_d_valid = 1'b1;
        s_cnt_clr = clr;
        @(posedge clk);
        #1;
        s_d_valid = 1'b0;
        s_cnt_clr = 1'b0;
    endtask

    initial begin
        logic [5:0] q_exp;
        logic [2:0] f_exp [6];

        reset_n = 1'b0;
        d_in = 0; d_valid = 0; overlap_en = 0; load_en = 0; cnt_clr = 0;
        load_pattern = 4'b0000;
        s_d_in = 0; s_d_valid = 0; s_cnt_clr = 0; s_load_en = 0;
        s_load_pattern = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_q",     {31'd0, q_out}, 32'd0);
        chk("reset_count", {24'd0, match_count}, 32'd0);
        chk("reset_fill",  {29'd0, fill}, 32'd0);
        reset_n = 1'b1;

        // Overlapping detection of 1010 in 101010
        overlap_en = 1'b1;
        q_exp = 6'b101000;
        f_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
        for (int i = 0; i < 6; i++) begin
            bit_in(~i[0], 1'b1);
            chk($sformatf("ovl_q_%0d", i), {31'd0, q_out}, {31'd0, q_exp[i]});
            chk($sformatf("ovl_fill_%0d", i), {29'd0, fill}, {29'd0, f_exp[i]});
        end
        chk("ovl_count", {24'd0, match_count}, 32'd2);
        bit_in(1'b1, 1'b0);
        chk("gap_q", {31'd0, q_out}, 32'd0);
        chk("gap_fill", {29'd0, fill}, 32'd4);

        // Load clears history/fill; clear counter in the same cycle
        load(4'b1010, 1'b1);
        chk("load_fill",  {29'd0, fill}, 32'd0);
        chk("load_q",     {31'd0, q_out}, 32'd0);
        chk("load_count", {24'd0, match_count}, 32'd0);

        // Non-overlapping detection
        overlap_en = 1'b0;
        q_exp = 6'b001000;
        f_exp = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2};
        for (int i = 0; i < 6; i++) begin
            bit_in(~i[0], 1'b1);
            chk($sformatf("novl_q_%0d", i), {31'd0, q_out}, {31'd0, q_exp[i]});
            chk($sformatf("novl_fill_%0d", i), {29'd0, fill}, {29'd0, f_exp[i]});
        end
        chk("novl_count", {24'd0, match_count}, 32'd1);

        // Invalid gap must not break the pattern
        load(4'b1010, 1'b0);
        overlap_en = 1'b1;
        bit_in(1'b1, 1'b1); chk("gapseq_q0", {31'd0, q_out}, 32'd0);
        bit_in(1'b0, 1'b1); chk("gapseq_q1", {31'd0, q_out}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            bit_in(1'b1, 1'b0);
            chk($sformatf("gapseq_hold_q_%0d", i), {31'd0, q_out}, 32'd0);
        end
        chk("gapseq_fill", {29'd0, fill}, 32'd2);
        bit_in(1'b1, 1'b1); chk("gapseq_q2", {31'd0, q_out}, 32'd0);
        bit_in(1'b0, 1'b1); chk("gapseq_q3", {31'd0, q_out}, 32'd1);
        chk("gapseq_count", {24'd0, match_count}, 32'd2);

        // Pattern 1111 with continuous ones: back-to-back pulses
        load(4'b1111, 1'b0);
        q_exp = 6'b111000;
        for (int i = 0; i < 6; i++) begin
            bit_in(1'b1, 1'b1);
            chk($sformatf("ones_q_%0d", i), {31'd0, q_out}, {31'd0, q_exp[i]});
        end
        chk("ones_count", {24'd0, match_count}, 32'd5);

        // Mode change alone leaves history and fill intact
        overlap_en = 1'b0;
        bit_in(1'b0, 1'b0);
        chk("mode_fill", {29'd0, fill}, 32'd4);
        bit_in(1'b1, 1'b1);
        chk("mode_q", {31'd0, q_out}, 32'd1);
        chk("mode_fill_after", {29'd0, fill}, 32'd0);
        chk("mode_count", {24'd0, match_count}, 32'd6);

        // Asynchronous reset mid-stream
        load(4'b0000, 1'b0);
        overlap_en = 1'b1;
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        bit_in(1'b1, 1'b1);
        chk("pre_rst_fill", {29'd0, fill}, 32'd3);
        reset_n = 1'b0;
        #2;
        chk("arst_q",     {31'd0, q_out}, 32'd0);
        chk("arst_fill",  {29'd0, fill}, 32'd0);
        chk("arst_count", {24'd0, match_count}, 32'd0);
        reset_n = 1'b1;
        bit_in(1'b0, 1'b1);
        chk("post_rst_q", {31'd0, q_out}, 32'd0);
        chk("post_rst_fill", {29'd0, fill}, 32'd1);
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        bit_in(1'b1, 1'b1);
        chk("post_rst_q4", {31'd0, q_out}, 32'd0);
        bit_in(1'b0, 1'b1);
        chk("post_rst_match", {31'd0, q_out}, 32'd1);

        // Saturating 2-bit counter
        for (int i = 0; i < 10; i++) begin
            sbit(~i[0], 1'b0);
        end
        chk("sat_count_4", {30'd0, s_match_count}, 32'd3);
        sbit(1'b1, 1'b0);
        sbit(1'b0, 1'b0);
        chk("sat_q_5", {31'd0, s_q_out}, 32'd1);
        chk("sat_count_5", {30'd0, s_match_count}, 32'd3);
        sbit(1'b1, 1'b0);
        sbit(1'b0, 1'b1);
        chk("sat_clr_q", {31'd0, s_q_out}, 32'd1);
        chk("sat_clr_count", {30'd0, s_match_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_seq_detector.md
PROG_SEQ_DETECTOR -- requirements
Module: prog_seq_detector

Interface
REQ-001 SHALL provide parameter SEQ_LEN, default 4, legal range 2..16, the pattern length in bits.
REQ-002 SHALL provide parameter RST_PATTERN, default 4'b1010 (width SEQ_LEN), the pattern loaded at reset.
REQ-003 SHALL provide parameter CNT_W, default 8, the width of the match counter.
REQ-004 SHALL provide clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL provide reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL provide d_in, input, 1, the serial data bit.
REQ-007 SHALL provide d_valid, input, 1, d_in qualifier; bits with d_valid=0 are ignored entirely.
REQ-008 SHALL provide overlap_en, input, 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL provide load_en, input, 1, pattern load strobe.
REQ-010 SHALL provide load_pattern, input, SEQ_LEN, the new pattern; MSB is the first bit received.
REQ-011 SHALL provide cnt_clr, input, 1, synchronous clear of match_count.
REQ-012 SHALL provide q_out, output, 1, registered match pulse (Moore).
REQ-013 SHALL provide match_count, output, CNT_W, saturating count of matches.
REQ-014 SHALL provide fill, output, clog2(SEQ_LEN+1), number of valid bits held in history, 0..SEQ_LEN.

Function
REQ-015 SHALL hold internal state: pattern register, history shift register (SEQ_LEN bits), fill counter, q_out register, match_count.
REQ-016 SHALL, on a cycle with d_valid=1 and load_en=0, shift d_in into the history LSB (history = {history[SEQ_LEN-2:0], d_in}) and increment fill, saturating at SEQ_LEN.
REQ-017 SHALL declare a match on a valid cycle when post-shift fill equals SEQ_LEN and the post-shift history equals the pattern.
REQ-018 SHALL assert q_out for exactly the one cycle following the match cycle; q_out SHALL be 0 otherwise, with no combinational path from any input to q_out.
REQ-019 SHALL, on a match with overlap_en=1, keep history and fill, so a suffix of the matched bits can start the next match.
REQ-020 SHALL, on a match with overlap_en=0, set fill to 0 so that the next match needs SEQ_LEN fresh valid bits.
REQ-021 SHALL permit back-to-back q_out pulses on consecutive valid cycles in overlap mode, e.g. pattern 1111 with continuous 1s.
REQ-022 SHALL, on a cycle with d_valid=0, leave history and fill unchanged and drive q_out to 0 on the next cycle.
REQ-023 SHALL, when load_en=1, update the pattern with load_pattern, clear history and fill to 0, ignore d_valid that cycle, and drive q_out to 0 on the next cycle.
REQ-024 SHALL increment match_count by 1 on each match, holding at 2^CNT_W-1 with no wrap.
REQ-025 SHALL give cnt_clr priority over an increment in the same cycle, so match_count becomes 0.
REQ-026 SHALL sample overlap_en only on match cycles; a mode change SHALL NOT alter history or fill.

Reset
REQ-027 SHALL, while reset_n=0, immediately force q_out=0, match_count=0, fill=0, history=0 and pattern=RST_PATTERN, independent of clk.
REQ-028 SHALL, after reset_n deasserts mid-stream, discard all bits received before reset; the first match needs SEQ_LEN new valid bits.

Verification
REQ-029 SHALL cover: defaults, overlap_en=1, d_valid=1, stream 1,0,1,0,1,0 -> q_out high in the cycles after the 4th and 6th bits; match_count=2.
REQ-030 SHALL cover: same stream with overlap_en=0 -> q_out high only after the 4th bit; match_count=1; fill=2 at the end.
REQ-031 SHALL cover: stream 1,0,[d_valid=0 for 3 cycles],1,0 -> a single q_out pulse after the final 0; no pulse during the gap.
REQ-032 SHALL cover: load_en with load_pattern=4'b1111, then overlap_en=1 and six 1s -> q_out high after bits 4, 5 and 6, i.e. three consecutive cycles.
REQ-033 SHALL cover: CNT_W=2 with 5 matches -> match_count saturates at 3; cnt_clr asserted together with a match -> 0.
REQ-034 SHALL cover: reset_n pulsed low between clk edges after 1,0,1 -> q_out, fill and match_count read 0 before the next edge; a following 0 produces no pulse.
